// File: rtl/hazard_pkg.sv
// Shared types for the hazard / forwarding unit: forward mux selects,
// the per-stage register tag carried down the shadow pipeline, and the
// tag comparison used by every match.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
      logic       valid;
   } stage_tag_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   localparam stage_tag_t TAG_BUBBLE = '0;

   // x0 is hard-wired to zero, so a tag targeting it never produces data.
   function automatic logic tag_hit(input stage_tag_t tag, input logic [4:0] rs);
      return tag.valid && tag.reg_write && (tag.rd != REG_X0) && (tag.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward select for one source register: compares it against the EX, MEM
// and WB tags and picks the newest producer.
module fwd_select
   import hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic       used,
   input  stage_tag_t ex_tag,
   input  stage_tag_t mem_tag,
   input  stage_tag_t wb_tag,
   output fwd_sel_t   sel,
   output logic       bypass
);

   // Priority EX > MEM > WB; a load in EX cannot forward yet (load-use stall).
   always_comb begin
      sel    = FWD_RF;
      bypass = 1'b0;
      if (used) begin
         if (tag_hit(ex_tag, rs) && !ex_tag.mem_read) begin
            sel = FWD_MEM;
         end else if (tag_hit(mem_tag, rs)) begin
            sel = FWD_WB;
         end else if (tag_hit(wb_tag, rs)) begin
            bypass = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and EX forwarding for a 5-stage pipeline. Tracks the
// destination tags of the instructions in EX/MEM/WB, registers forward
// selects for the EX muxes, and drives stall / bubble / flush controls.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             branch_taken,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       forward_a,
   output logic [1:0]       forward_b,
   output logic             wb_bypass_a,
   output logic             wb_bypass_b,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam int FC_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

   stage_tag_t       ex_tag;
   stage_tag_t       mem_tag;
   stage_tag_t       wb_tag;
   fwd_sel_t         sel_a;
   fwd_sel_t         sel_b;
   fwd_sel_t         fwd_a_q;
   fwd_sel_t         fwd_b_q;
   logic [FC_W-1:0]  flush_cnt;
   logic             use_a;
   logic             use_b;
   logic             flushing;
   logic             load_use;
   logic             stall;
   logic             advance;

   assign use_a = id_valid && id_uses_rs1;
   assign use_b = id_valid && id_uses_rs2;

   fwd_select u_sel_a (
      .rs      (id_rs1),
      .used    (use_a),
      .ex_tag  (ex_tag),
      .mem_tag (mem_tag),
      .wb_tag  (wb_tag),
      .sel     (sel_a),
      .bypass  (wb_bypass_a)
   );

   fwd_select u_sel_b (
      .rs      (id_rs2),
      .used    (use_b),
      .ex_tag  (ex_tag),
      .mem_tag (mem_tag),
      .wb_tag  (wb_tag),
      .sel     (sel_b),
      .bypass  (wb_bypass_b)
   );

   // A pending flush or a branch resolving this cycle overrides the load-use
   // stall: the dependent instruction is on the wrong path anyway.
   always_comb begin
      flushing = (flush_cnt != '0);
      load_use = ex_tag.valid && ex_tag.mem_read && (ex_tag.rd != REG_X0) &&
                 ((use_a && (ex_tag.rd == id_rs1)) || (use_b && (ex_tag.rd == id_rs2)));
      stall    = load_use && !flushing && !branch_taken;
      advance  = !stall && !flushing;
   end

   assign pc_write     = !stall;
   assign if_id_write  = !stall;
   assign if_id_flush  = flushing;
   assign id_ex_bubble = stall || flushing;
   assign forward_a    = fwd_a_q;
   assign forward_b    = fwd_b_q;

   // Shadow tag pipeline and registered forward selects for the EX stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_tag  <= TAG_BUBBLE;
         mem_tag <= TAG_BUBBLE;
         wb_tag  <= TAG_BUBBLE;
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         wb_tag  <= mem_tag;
         mem_tag <= ex_tag;
         if (advance) begin
            ex_tag  <= '{rd: id_rd, reg_write: id_reg_write,
                         mem_read: id_mem_read, valid: id_valid};
            fwd_a_q <= sel_a;
            fwd_b_q <= sel_b;
         end else begin
            ex_tag  <= TAG_BUBBLE;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
         end
      end
   end

   // Flush window down-counter; a new taken branch restarts the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt <= '0;
      end else if (branch_taken) begin
         flush_cnt <= FC_W'(FLUSH_CYCLES);
      end else if (flushing) begin
         flush_cnt <= flush_cnt - FC_W'(1);
      end
   end

   // Saturating event counters for stalls and taken branches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
         if (branch_taken && (flush_count != '1)) begin
            flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

endmodule
